alu_exec: RTL and testbench

//  Execution stage directly downstream of the reservation station. Takes one ready op per cycle
//  (type, operands, ROB id) and broadcasts the result on the ALU CDB (rs_fi/rs_value/rs_rob_id),

---
 rtl/alu_exec_pkg.sv | 41 ++++
 rtl/alu_exec_if.sv | 25 ++
 rtl/alu_exec_chk.sv | 17 +
 rtl/alu_exec_divider.sv | 138 +++++++++++++
 rtl/alu_exec.sv | 151 +++++++++++++++
 tb/tb_alu_exec.sv | 331 +++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_exec_pkg.sv
// Shared types and constants for the ALU execution stage: op encodings (shared with RS/decoder),
// widths and small datapath helpers.
package alu_exec_pkg;

  localparam int XLEN         = 32;
  localparam int DIV_STEPS    = 32;
  localparam int CNT_W        = $clog2(DIV_STEPS);
  localparam int RS_TYPE_BIT  = 5;
  localparam int ROB_SIZE_BIT = 4;

  typedef enum logic [RS_TYPE_BIT-1:0] {
    ALU_ADD    = 5'd0,  ALU_SUB   = 5'd1,  ALU_AND  = 5'd2,  ALU_OR   = 5'd3,
    ALU_XOR    = 5'd4,  ALU_SLL   = 5'd5,  ALU_SRL  = 5'd6,  ALU_SRA  = 5'd7,
    ALU_SLT    = 5'd8,  ALU_SLTU  = 5'd9,  ALU_BEQ  = 5'd10, ALU_BNE  = 5'd11,
    ALU_BLT    = 5'd12, ALU_BGE   = 5'd13, ALU_BLTU = 5'd14, ALU_BGEU = 5'd15,
    ALU_MUL    = 5'd16, ALU_MULH  = 5'd17, ALU_MULHSU = 5'd18, ALU_MULHU = 5'd19,
    ALU_DIV    = 5'd20, ALU_DIVU  = 5'd21, ALU_REM  = 5'd22, ALU_REMU = 5'd23
  } alu_op_e;

  typedef enum logic [0:0] {
    DS_IDLE = 1'b0,
    DS_DIV  = 1'b1
  } div_state_e;

  function automatic logic is_div_op(input alu_op_e op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  function automatic logic div_is_signed(input alu_op_e op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  function automatic logic div_is_rem(input alu_op_e op);
    return (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  function automatic logic [XLEN-1:0] magnitude(input logic sgn, input logic [XLEN-1:0] x);
    return (sgn && x[XLEN-1]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Issue bus from the reservation station plus the ALU CDB broadcast.
interface alu_exec_if;
  import alu_exec_pkg::*;

  logic                    alu_input;
  logic [RS_TYPE_BIT-1:0]  arith_type;
  logic [XLEN-1:0]         alu_r1_val;
  logic [XLEN-1:0]         alu_r2_val;
  logic [ROB_SIZE_BIT-1:0] inst_rob_id;
  logic                    alu_busy;
  logic                    rs_fi;
  logic [XLEN-1:0]         rs_value;
  logic [ROB_SIZE_BIT-1:0] rs_rob_id;

  modport master (
    output alu_input, arith_type, alu_r1_val, alu_r2_val, inst_rob_id,
    input  alu_busy, rs_fi, rs_value, rs_rob_id
  );

  modport slave (
    input  alu_input, arith_type, alu_r1_val, alu_r2_val, inst_rob_id,
    output alu_busy, rs_fi, rs_value, rs_rob_id
  );

endinterface

// File: rtl/alu_exec_chk.sv
// Protocol checker for alu_exec: the RS must not issue while the divider is occupied.
module alu_exec_chk (
  input logic clk_in,
  input logic rst_n_in,
  input logic rdy_in,
  input logic alu_input,
  input logic alu_busy
);

  property p_no_issue_when_busy;
    @(posedge clk_in) disable iff (!rst_n_in) !(rdy_in && alu_input && alu_busy);
  endproperty

  a_no_issue_when_busy: assert property (p_no_issue_when_busy)
    else $error("alu_exec_chk: issue while alu_busy, op dropped");

endmodule

// File: rtl/alu_exec_divider.sv
// Iterative restoring divider (one quotient bit per cycle on operand magnitudes, sign fix-up on
// the final step). Holds the IDLE/DIV FSM and step counter; flush returns it to IDLE.
module alu_divider
  import alu_exec_pkg::*;
(
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    rdy_in,
  input  logic                    flush_i,
  input  logic                    start_i,
  input  logic                    signed_i,
  input  logic                    rem_sel_i,
  input  logic [XLEN-1:0]         dividend_i,
  input  logic [XLEN-1:0]         divisor_i,
  input  logic [ROB_SIZE_BIT-1:0] rob_id_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [XLEN-1:0]         result_o,
  output logic [ROB_SIZE_BIT-1:0] rob_id_o
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_STEPS - 1);

  div_state_e              state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [XLEN-1:0]         rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic                    q_neg_q, q_neg_d, r_neg_q, r_neg_d, rem_sel_q, rem_sel_d;
  logic [ROB_SIZE_BIT-1:0] rob_q, rob_d;
  logic [XLEN:0]           shifted_s, diff_s;
  logic [XLEN-1:0]         step_rem_s, step_quo_s;
  logic                    done_s;

  // One restoring step: shift in the next dividend bit, keep the difference if it fits.
  always_comb begin
    shifted_s = {rem_q, quo_q[XLEN-1]};
    diff_s    = shifted_s - {1'b0, dvs_q};
    if (diff_s[XLEN]) begin
      step_rem_s = shifted_s[XLEN-1:0];
      step_quo_s = {quo_q[XLEN-2:0], 1'b0};
    end else begin
      step_rem_s = diff_s[XLEN-1:0];
      step_quo_s = {quo_q[XLEN-2:0], 1'b1};
    end
  end

  // Next-state: load magnitudes on start, iterate in DIV, flush wins over everything.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    rem_sel_d = rem_sel_q;
    rob_d     = rob_q;
    done_s    = 1'b0;
    case (state_q)
      DS_IDLE: begin
        if (start_i) begin
          state_d   = DS_DIV;
          count_d   = {CNT_W{1'b0}};
          rem_d     = 32'd0;
          quo_d     = magnitude(signed_i, dividend_i);
          dvs_d     = magnitude(signed_i, divisor_i);
          // A zero divisor keeps the all-ones quotient unsigned-looking.
          q_neg_d   = signed_i && (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]) && (divisor_i != 32'd0);
          r_neg_d   = signed_i && dividend_i[XLEN-1];
          rem_sel_d = rem_sel_i;
          rob_d     = rob_id_i;
        end else begin
          state_d = DS_IDLE;
        end
      end
      DS_DIV: begin
        rem_d = step_rem_s;
        quo_d = step_quo_s;
        if (count_q == LAST_STEP) begin
          done_s  = 1'b1;
          state_d = DS_IDLE;
          count_d = {CNT_W{1'b0}};
        end else begin
          count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = DS_IDLE;
        count_d = {CNT_W{1'b0}};
      end
    endcase
    if (flush_i) begin
      state_d = DS_IDLE;
      count_d = {CNT_W{1'b0}};
      done_s  = 1'b0;
    end else begin
      done_s = done_s;
    end
  end

  // State and datapath registers; frozen while rdy_in is low.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= DS_IDLE;
      count_q   <= {CNT_W{1'b0}};
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dvs_q     <= 32'd0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      rem_sel_q <= 1'b0;
      rob_q     <= {ROB_SIZE_BIT{1'b0}};
    end else if (rdy_in) begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      rem_sel_q <= rem_sel_d;
      rob_q     <= rob_d;
    end
  end

  // Signed fix-up of the final step's quotient/remainder.
  always_comb begin
    if (rem_sel_q) begin
      result_o = r_neg_q ? (~step_rem_s + 32'd1) : step_rem_s;
    end else begin
      result_o = q_neg_q ? (~step_quo_s + 32'd1) : step_quo_s;
    end
  end

  assign busy_o   = (state_q == DS_DIV);
  assign done_o   = done_s;
  assign rob_id_o = rob_q;

endmodule

// File: rtl/alu_exec.sv
// ALU execution stage: combinational ALU/multiplier, iterative divider, registered CDB output.
// Optional ALU_EARLY_DIV_EN: trivial divides complete in one cycle without using the divider.
module alu_exec
  import alu_exec_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       rdy_in,
  input  logic       rob_clear,
  alu_exec_if.slave  bus
);

  alu_op_e                 op_s;
  logic [XLEN-1:0]         a_s, b_s, alu_res_s, early_res_s, div_res_s;
  logic [2*XLEN-1:0]       mul_a_s, mul_b_s, prod_s;
  logic                    op_div_s, div_sgn_s, div_rem_s, early_s;
  logic                    accept_s, start_div_s, one_cycle_s, div_busy_s, div_done_s;
  logic [ROB_SIZE_BIT-1:0] div_rob_s;
  logic                    rs_fi_q, rs_fi_d;
  logic [XLEN-1:0]         rs_value_q, rs_value_d;
  logic [ROB_SIZE_BIT-1:0] rs_rob_id_q, rs_rob_id_d;

  assign op_s      = alu_op_e'(bus.arith_type);
  assign a_s       = bus.alu_r1_val;
  assign b_s       = bus.alu_r2_val;
  assign op_div_s  = is_div_op(op_s);
  assign div_sgn_s = div_is_signed(op_s);
  assign div_rem_s = div_is_rem(op_s);

  // Issue while busy is dropped rather than corrupting the divide in flight.
  assign accept_s    = bus.alu_input && !div_busy_s;
  assign start_div_s = accept_s && op_div_s && !early_s;
  assign one_cycle_s = accept_s && (!op_div_s || early_s);

  assign mul_a_s = (op_s == ALU_MULH || op_s == ALU_MULHSU) ? {{XLEN{a_s[XLEN-1]}}, a_s}
                                                            : {{XLEN{1'b0}}, a_s};
  assign mul_b_s = (op_s == ALU_MULH) ? {{XLEN{b_s[XLEN-1]}}, b_s} : {{XLEN{1'b0}}, b_s};
  assign prod_s  = mul_a_s * mul_b_s;

`ifdef ALU_EARLY_DIV_EN
  // Zero divisor, signed overflow and |dividend| < |divisor| have closed-form results.
  always_comb begin
    early_s     = 1'b0;
    early_res_s = 32'd0;
    if (b_s == 32'd0) begin
      early_s     = 1'b1;
      early_res_s = div_rem_s ? a_s : 32'hFFFF_FFFF;
    end else if (div_sgn_s && (a_s == 32'h8000_0000) && (b_s == 32'hFFFF_FFFF)) begin
      early_s     = 1'b1;
      early_res_s = div_rem_s ? 32'd0 : 32'h8000_0000;
    end else if (magnitude(div_sgn_s, a_s) < magnitude(div_sgn_s, b_s)) begin
      early_s     = 1'b1;
      early_res_s = div_rem_s ? a_s : 32'd0;
    end else begin
      early_s     = 1'b0;
      early_res_s = 32'd0;
    end
  end
`else
  assign early_s     = 1'b0;
  assign early_res_s = 32'd0;
`endif

  // Single-cycle result for everything except the iterative divide.
  always_comb begin
    alu_res_s = 32'd0;
    case (op_s)
      ALU_ADD:    alu_res_s = a_s + b_s;
      ALU_SUB:    alu_res_s = a_s - b_s;
      ALU_AND:    alu_res_s = a_s & b_s;
      ALU_OR:     alu_res_s = a_s | b_s;
      ALU_XOR:    alu_res_s = a_s ^ b_s;
      ALU_SLL:    alu_res_s = a_s << b_s[4:0];
      ALU_SRL:    alu_res_s = a_s >> b_s[4:0];
      ALU_SRA:    alu_res_s = XLEN'($signed(a_s) >>> b_s[4:0]);
      ALU_SLT:    alu_res_s = {31'd0, $signed(a_s) < $signed(b_s)};
      ALU_SLTU:   alu_res_s = {31'd0, a_s < b_s};
      ALU_BEQ:    alu_res_s = {31'd0, a_s == b_s};
      ALU_BNE:    alu_res_s = {31'd0, a_s != b_s};
      ALU_BLT:    alu_res_s = {31'd0, $signed(a_s) < $signed(b_s)};
      ALU_BGE:    alu_res_s = {31'd0, $signed(a_s) >= $signed(b_s)};
      ALU_BLTU:   alu_res_s = {31'd0, a_s < b_s};
      ALU_BGEU:   alu_res_s = {31'd0, a_s >= b_s};
      ALU_MUL:    alu_res_s = prod_s[XLEN-1:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  alu_res_s = prod_s[2*XLEN-1:XLEN];
      ALU_DIV,
      ALU_DIVU,
      ALU_REM,
      ALU_REMU:   alu_res_s = early_res_s;
      default:    alu_res_s = 32'd0;
    endcase
  end

  alu_divider u_div (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .rdy_in     (rdy_in),
    .flush_i    (rob_clear),
    .start_i    (start_div_s),
    .signed_i   (div_sgn_s),
    .rem_sel_i  (div_rem_s),
    .dividend_i (a_s),
    .divisor_i  (b_s),
    .rob_id_i   (bus.inst_rob_id),
    .busy_o     (div_busy_s),
    .done_o     (div_done_s),
    .result_o   (div_res_s),
    .rob_id_o   (div_rob_s)
  );

  // CDB source select; value/rob hold when nothing completes.
  always_comb begin
    rs_fi_d     = 1'b0;
    rs_value_d  = rs_value_q;
    rs_rob_id_d = rs_rob_id_q;
    if (rob_clear) begin
      rs_fi_d = 1'b0;
    end else if (div_done_s) begin
      rs_fi_d     = 1'b1;
      rs_value_d  = div_res_s;
      rs_rob_id_d = div_rob_s;
    end else if (one_cycle_s) begin
      rs_fi_d     = 1'b1;
      rs_value_d  = alu_res_s;
      rs_rob_id_d = bus.inst_rob_id;
    end else begin
      rs_fi_d = 1'b0;
    end
  end

  // CDB output registers, frozen while rdy_in is low.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rs_fi_q     <= 1'b0;
      rs_value_q  <= 32'd0;
      rs_rob_id_q <= {ROB_SIZE_BIT{1'b0}};
    end else if (rdy_in) begin
      rs_fi_q     <= rs_fi_d;
      rs_value_q  <= rs_value_d;
      rs_rob_id_q <= rs_rob_id_d;
    end
  end

  assign bus.alu_busy  = div_busy_s;
  assign bus.rs_fi     = rs_fi_q;
  assign bus.rs_value  = rs_value_q;
  assign bus.rs_rob_id = rs_rob_id_q;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed corners plus random ops against a behavioural model.
module tb_alu_exec;
  import alu_exec_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b1;
  logic rob_clear = 1'b0;
  int   errors = 0;
  int   checks = 0;

  alu_exec_if bus();

  alu_exec dut (
    .clk_in    (clk),
    .rst_n_in  (rst_n),
    .rdy_in    (rdy),
    .rob_clear (rob_clear),
    .bus       (bus)
  );

  alu_exec_chk u_chk (
    .clk_in    (clk),
    .rst_n_in  (rst_n),
    .rdy_in    (rdy),
    .alu_input (bus.alu_input),
    .alu_busy  (bus.alu_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    longint      lp;
    logic [63:0] up;
    sa = a;
    sb = b;
    case (op)
      ALU_ADD:    return a + b;
      ALU_SUB:    return a - b;
      ALU_AND:    return a & b;
      ALU_OR:     return a | b;
      ALU_XOR:    return a ^ b;
      ALU_SLL:    return a << b[4:0];
      ALU_SRL:    return a >> b[4:0];
      ALU_SRA:    return 32'(sa >>> b[4:0]);
      ALU_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU:   return (a < b) ? 32'd1 : 32'd0;
      ALU_BEQ:    return (a == b) ? 32'd1 : 32'd0;
      ALU_BNE:    return (a != b) ? 32'd1 : 32'd0;
      ALU_BLT:    return (sa < sb) ? 32'd1 : 32'd0;
      ALU_BGE:    return (sa >= sb) ? 32'd1 : 32'd0;
      ALU_BLTU:   return (a < b) ? 32'd1 : 32'd0;
      ALU_BGEU:   return (a >= b) ? 32'd1 : 32'd0;
      ALU_MUL:    return a * b;
      ALU_MULH:   begin lp = longint'(sa) * longint'(sb); return lp[63:32]; end
      ALU_MULHSU: begin lp = longint'(sa) * longint'({32'd0, b}); return lp[63:32]; end
      ALU_MULHU:  begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      ALU_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      ALU_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      ALU_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      ALU_REMU:   return (b == 32'd0) ? a : a % b;
      default:    return 32'd0;
    endcase
  endfunction

  // Cycles from issue to the CDB pulse for a given op.
  function automatic int exp_lat(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    logic        sgn;
    logic [31:0] ma, mb;
    if (!(op == ALU_DIV || op == ALU_DIVU || op == ALU_REM || op == ALU_REMU)) return 1;
    sgn = (op == ALU_DIV || op == ALU_REM);
    ma  = (sgn && a[31]) ? 32'd0 - a : a;
    mb  = (sgn && b[31]) ? 32'd0 - b : b;
`ifdef ALU_EARLY_DIV_EN
    if (b == 32'd0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || ma < mb) return 1;
`else
    if (ma == mb && ma != ma) return 1;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      4:       return $urandom_range(0, 40);
      default: return $urandom;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input alu_op_e op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] rob);
    bus.alu_input   = 1'b1;
    bus.arith_type  = op;
    bus.alu_r1_val  = a;
    bus.alu_r2_val  = b;
    bus.inst_rob_id = rob;
  endtask

  // Issue one op and wait (bounded) for its CDB pulse; lat=0 means no pulse seen.
  task automatic issue_wait(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] rob, output int lat, output logic [31:0] val,
                            output logic [3:0] rid);
    logic found;
    found = 1'b0;
    lat   = 0;
    val   = 32'd0;
    rid   = 4'd0;
    drive(op, a, b, rob);
    step();
    bus.alu_input = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (!found && bus.rs_fi === 1'b1) begin
        found = 1'b1;
        lat   = k;
        val   = bus.rs_value;
        rid   = bus.rs_rob_id;
      end
      if (!found) step();
    end
  endtask

  task automatic test_reset();
    checks++; if (bus.rs_fi !== 1'b0) begin errors++; $display("FAIL reset_fi: got %0b expected 0", bus.rs_fi); end
    checks++; if (bus.rs_value !== 32'd0) begin errors++; $display("FAIL reset_value: got %0h expected 0", bus.rs_value); end
    checks++; if (bus.rs_rob_id !== 4'd0) begin errors++; $display("FAIL reset_rob: got %0h expected 0", bus.rs_rob_id); end
    checks++; if (bus.alu_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", bus.alu_busy); end
    #10 rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_ops();
    int lat; logic [31:0] v; logic [3:0] r;
    issue_wait(ALU_ADD, 32'd5, 32'd7, 4'd3, lat, v, r);
    checks++; if (lat != 1) begin errors++; $display("FAIL add_latency: got %0d expected 1", lat); end
    checks++; if (v !== 32'd12) begin errors++; $display("FAIL add_value: got %0h expected c", v); end
    checks++; if (r !== 4'd3) begin errors++; $display("FAIL add_rob: got %0h expected 3", r); end
    step();
    checks++; if (bus.rs_fi !== 1'b0) begin errors++; $display("FAIL add_pulse_end: got %0b expected 0", bus.rs_fi); end
    issue_wait(ALU_SRA, 32'h8000_0000, 32'h24, 4'd1, lat, v, r);
    checks++; if (lat != 1 || v !== 32'hF800_0000) begin errors++; $display("FAIL sra: got %0h lat %0d expected f8000000 lat 1", v, lat); end
    issue_wait(ALU_BLTU, 32'd1, 32'hFFFF_FFFF, 4'd2, lat, v, r);
    checks++; if (lat != 1 || v !== 32'd1) begin errors++; $display("FAIL bltu: got %0h lat %0d expected 1 lat 1", v, lat); end
    issue_wait(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4, lat, v, r);
    checks++; if (lat != 1 || v !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu: got %0h lat %0d expected fffffffe lat 1", v, lat); end
    step();
  endtask

  task automatic test_div();
    int lat; logic [31:0] v; logic [3:0] r;
    drive(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 4'd5);
    step();
    bus.alu_input = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      checks++;
      if (bus.alu_busy !== 1'b1 || bus.rs_fi !== 1'b0) begin
        errors++; $display("FAIL div_busy_window: cycle %0d busy %0b fi %0b expected busy 1 fi 0", k, bus.alu_busy, bus.rs_fi);
      end
      step();
    end
    checks++; if (bus.rs_fi !== 1'b1) begin errors++; $display("FAIL div_done_fi: got %0b expected 1", bus.rs_fi); end
    checks++; if (bus.rs_value !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_value: got %0h expected fffffffd", bus.rs_value); end
    checks++; if (bus.rs_rob_id !== 4'd5) begin errors++; $display("FAIL div_rob: got %0h expected 5", bus.rs_rob_id); end
    checks++; if (bus.alu_busy !== 1'b0) begin errors++; $display("FAIL div_busy_drop: got %0b expected 0", bus.alu_busy); end
    issue_wait(ALU_ADD, 32'd100, 32'd1, 4'd6, lat, v, r);
    checks++; if (lat != 1 || v !== 32'd101 || r !== 4'd6) begin errors++; $display("FAIL add_after_div: got %0h rob %0h lat %0d expected 65 rob 6 lat 1", v, r, lat); end
    issue_wait(ALU_REM, 32'hFFFF_FFF9, 32'd2, 4'd7, lat, v, r);
    checks++; if (lat != 33 || v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_neg: got %0h lat %0d expected ffffffff lat 33", v, lat); end
    issue_wait(ALU_DIVU, 32'd10, 32'd0, 4'd8, lat, v, r);
    checks++; if (lat != exp_lat(ALU_DIVU, 32'd10, 32'd0) || v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_by_zero: got %0h lat %0d expected ffffffff", v, lat); end
    issue_wait(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 4'd9, lat, v, r);
    checks++; if (lat != exp_lat(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF) || v !== 32'd0) begin errors++; $display("FAIL rem_overflow: got %0h lat %0d expected 0", v, lat); end
    issue_wait(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 4'd10, lat, v, r);
    checks++; if (v !== 32'h8000_0000) begin errors++; $display("FAIL div_overflow: got %0h expected 80000000", v); end
    issue_wait(ALU_REMU, 32'h1234_5678, 32'd0, 4'd11, lat, v, r);
    checks++; if (v !== 32'h1234_5678) begin errors++; $display("FAIL remu_by_zero: got %0h expected 12345678", v); end
    issue_wait(ALU_DIV, 32'd3, 32'hFFFF_FFFB, 4'd12, lat, v, r);
    checks++; if (lat != exp_lat(ALU_DIV, 32'd3, 32'hFFFF_FFFB) || v !== 32'd0) begin errors++; $display("FAIL div_small: got %0h lat %0d expected 0", v, lat); end
    step();
  endtask

  task automatic test_random();
    int lat; logic [31:0] v, a, b, e; logic [3:0] r, rob; alu_op_e op;
    for (int i = 0; i < 60; i++) begin
      op  = alu_op_e'(5'($urandom_range(0, 23)));
      a   = rnd_operand();
      b   = rnd_operand();
      rob = 4'($urandom_range(0, 15));
      e   = ref_alu(op, a, b);
      issue_wait(op, a, b, rob, lat, v, r);
      checks++;
      if (lat != exp_lat(op, a, b) || v !== e || r !== rob) begin
        errors++; $display("FAIL random_%0s: a %0h b %0h got %0h rob %0h lat %0d expected %0h rob %0h lat %0d",
                           op.name(), a, b, v, r, lat, e, rob, exp_lat(op, a, b));
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    for (int i = 0; i < 5; i++) begin
      a = $urandom; b = $urandom;
      drive(ALU_XOR, a, b, 4'(i));
      step();
      checks++;
      if (bus.rs_fi !== 1'b1 || bus.rs_value !== (a ^ b) || bus.rs_rob_id !== 4'(i)) begin
        errors++; $display("FAIL b2b_%0d: fi %0b value %0h rob %0h expected 1 %0h %0h", i, bus.rs_fi, bus.rs_value, bus.rs_rob_id, a ^ b, i);
      end
    end
    bus.alu_input = 1'b0;
    step();
    checks++; if (bus.rs_fi !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %0b expected 0", bus.rs_fi); end
  endtask

  task automatic test_flush();
    int lat, pulses; logic [31:0] v; logic [3:0] r;
    drive(ALU_DIV, 32'd1000, 32'd7, 4'd6);
    step();
    bus.alu_input = 1'b0;
    for (int k = 1; k < 10; k++) step();
    rob_clear = 1'b1;
    step();
    rob_clear = 1'b0;
    checks++; if (bus.alu_busy !== 1'b0 || bus.rs_fi !== 1'b0) begin errors++; $display("FAIL flush_div: busy %0b fi %0b expected 0 0", bus.alu_busy, bus.rs_fi); end
    issue_wait(ALU_ADD, 32'd1, 32'd2, 4'd7, lat, v, r);
    checks++; if (lat != 1 || v !== 32'd3 || r !== 4'd7) begin errors++; $display("FAIL add_after_flush: got %0h rob %0h lat %0d expected 3 rob 7 lat 1", v, r, lat); end
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.rs_fi === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL flush_no_result: got %0d pulses expected 0", pulses); end
    drive(ALU_ADD, 32'd4, 32'd4, 4'd8);
    rob_clear = 1'b1;
    step();
    bus.alu_input = 1'b0;
    rob_clear = 1'b0;
    checks++; if (bus.rs_fi !== 1'b0) begin errors++; $display("FAIL flush_same_cycle: got %0b expected 0", bus.rs_fi); end
    step();
  endtask

  task automatic test_rdy_stall();
    int seen, got;
    logic [31:0] v;
    drive(ALU_DIV, 32'd100, 32'd7, 4'd13);
    step();
    bus.alu_input = 1'b0;
    seen = 0; v = 32'd0;
    for (int k = 1; k <= 45; k++) begin
      if (seen == 0 && bus.rs_fi === 1'b1) begin seen = k; v = bus.rs_value; end
      rdy = (k >= 5 && k <= 7) ? 1'b0 : 1'b1;
      if (seen == 0) step();
    end
    rdy = 1'b1;
    checks++; if (seen != 36 || v !== 32'd14) begin errors++; $display("FAIL div_stall: got %0h at cycle %0d expected e at cycle 36", v, seen); end
    step();
    drive(ALU_ADD, 32'd9, 32'd9, 4'd2);
    step();
    bus.alu_input = 1'b0;
    got = 0;
    for (int j = 0; j < 4; j++) begin
      rdy = (j >= 2) ? 1'b1 : 1'b0;
      if (j == 2) begin
        checks++; if (bus.rs_fi !== 1'b1 || bus.rs_value !== 32'd18 || bus.rs_rob_id !== 4'd2) begin
          errors++; $display("FAIL held_pulse: fi %0b value %0h rob %0h expected 1 12 2", bus.rs_fi, bus.rs_value, bus.rs_rob_id);
        end
      end
      if (rdy && bus.rs_fi === 1'b1) got++;
      step();
    end
    checks++; if (got != 1) begin errors++; $display("FAIL held_pulse_count: got %0d expected 1", got); end
  endtask

  task automatic test_reset_mid_div();
    int pulses;
    drive(ALU_ADD, 32'd5, 32'd7, 4'd3);
    step();
    drive(ALU_DIV, 32'd500, 32'd3, 4'd9);
    step();
    bus.alu_input = 1'b0;
    for (int k = 0; k < 5; k++) step();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.alu_busy !== 1'b0 || bus.rs_fi !== 1'b0 || bus.rs_value !== 32'd0 || bus.rs_rob_id !== 4'd0) begin
      errors++; $display("FAIL reset_mid_div: busy %0b fi %0b value %0h rob %0h expected all 0", bus.alu_busy, bus.rs_fi, bus.rs_value, bus.rs_rob_id);
    end
    #2 rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.rs_fi === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL reset_no_result: got %0d pulses expected 0", pulses); end
  endtask

  initial begin
    bus.alu_input   = 1'b0;
    bus.arith_type  = 5'd0;
    bus.alu_r1_val  = 32'd0;
    bus.alu_r2_val  = 32'd0;
    bus.inst_rob_id = 4'd0;
    #2;
    test_reset();
    test_basic_ops();
    test_div();
    test_back_to_back();
    test_random();
    test_flush();
    test_rdy_stall();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
